lag_meter: RTL

- Consumes the 8-bit ambient-light samples produced by the ALS SPI reader.
- Measures display input lag: clock cycles from the stimulus trigger until light first crosses a low threshold.
- Measures response time: cycles from that low-threshold crossing to a high-threshold crossing.
- Publishes one registered result per trigger to the reporting/UART stage downstream.

---
 rtl/lag_pkg.sv | 28 ++
 rtl/lag_meter_crossing_qual.sv | 52 +++++
 rtl/lag_meter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/lag_pkg.sv
// Shared types and constants for the display lag meter.
package lag_pkg;

  // Default width of the cycle counter and result fields.
  localparam int CNT_W_DEF = 32;

  // Widest counter the all-ones helper can describe.
  localparam int CNT_W_MAX = 64;

  // Measurement sequencer states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_LO = 2'd1,
    WAIT_HI = 2'd2,
    DONE    = 2'd3
  } state_e;

  // Value reported for a result field that was never measured.
  function automatic logic [CNT_W_MAX-1:0] all_ones(input int w);
    logic [CNT_W_MAX-1:0] m;
    m = '0;
    for (int i = 0; i < CNT_W_MAX; i++) begin
      if (i < w) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/lag_meter_crossing_qual.sv
// Threshold crossing qualifier: flags the sample that completes a crossing
// and supplies the cycle stamp that crossing should be reported with.
// Optional build macro LAG_CONFIRM_EN: a crossing needs two consecutive
// valid samples at or above the threshold, stamped at the first of the pair.
module crossing_qual
  import lag_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
`ifdef LAG_CONFIRM_EN
  input  logic             clk_i,
  input  logic             reset_i,
`endif
  input  logic             arm_i,
  input  logic [7:0]       sample_i,
  input  logic             sample_valid_i,
  input  logic [7:0]       threshold_i,
  input  logic [CNT_W-1:0] cnt_i,
  output logic             hit_o,
  output logic [CNT_W-1:0] hit_ts_o
);

  logic ge;
  assign ge = sample_valid_i && (sample_i >= threshold_i);

`ifdef LAG_CONFIRM_EN
  logic             cand_q;
  logic [CNT_W-1:0] cand_ts_q;

  // Hold a pending candidate until the next valid sample confirms or drops it.
  always_ff @(posedge clk_i) begin
    if (reset_i || !arm_i) begin
      cand_q    <= 1'b0;
      cand_ts_q <= '0;
    end else if (sample_valid_i) begin
      if (cand_q) begin
        cand_q <= 1'b0;
      end else begin
        cand_q    <= ge;
        cand_ts_q <= cnt_i;
      end
    end
  end

  assign hit_o    = arm_i && cand_q && ge;
  assign hit_ts_o = cand_ts_q;
`else
  assign hit_o    = arm_i && ge;
  assign hit_ts_o = cnt_i;
`endif

endmodule

// File: rtl/lag_meter.sv
// Display input-lag / response-time meter fed by ambient-light samples.
// Build macro LAG_CONFIRM_EN selects two-sample crossing confirmation.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a stimulus trigger
// WAIT_LO | counting cycles until light reaches the low threshold
// WAIT_HI | counting cycles until light reaches the high threshold
// DONE    | publish result fields and pulse result_valid for one cycle
module lag_meter
  import lag_pkg::*;
#(
  parameter int          CNT_W       = CNT_W_DEF,
  parameter int unsigned TIMEOUT_CYC = 100_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       sample,
  input  logic             sample_valid,
  input  logic             trigger,
  input  logic [7:0]       thr_lo,
  input  logic [7:0]       thr_hi,
  output logic             busy,
  output logic [CNT_W-1:0] lag_cycles,
  output logic [CNT_W-1:0] rise_cycles,
  output logic             timeout,
  output logic             result_valid
);

  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] ONES   = CNT_W'(all_ones(CNT_W));

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       thr_lo_q;
  logic [7:0]       thr_hi_q;
  logic [CNT_W-1:0] lag_q;
  logic [CNT_W-1:0] rise_q;
  logic [CNT_W-1:0] t_lo_q;
  logic             to_flag_q;

  logic             busy_q;
  logic [CNT_W-1:0] lag_cycles_q;
  logic [CNT_W-1:0] rise_cycles_q;
  logic             timeout_q;
  logic             result_valid_q;

  logic             arm_lo;
  logic             arm_hi;
  logic             lo_hit;
  logic             hi_hit;
  logic [CNT_W-1:0] lo_ts;
  logic [CNT_W-1:0] hi_ts;

  // The high qualifier also watches during WAIT_LO so a sample that clears
  // both thresholds at once finishes the measurement with zero rise time.
  assign arm_lo = (state_q == WAIT_LO);
  assign arm_hi = (state_q == WAIT_LO) || (state_q == WAIT_HI);

  crossing_qual #(.CNT_W(CNT_W)) u_qual_lo (
`ifdef LAG_CONFIRM_EN
    .clk_i          (clk),
    .reset_i        (reset),
`endif
    .arm_i          (arm_lo),
    .sample_i       (sample),
    .sample_valid_i (sample_valid),
    .threshold_i    (thr_lo_q),
    .cnt_i          (cnt_q),
    .hit_o          (lo_hit),
    .hit_ts_o       (lo_ts)
  );

  crossing_qual #(.CNT_W(CNT_W)) u_qual_hi (
`ifdef LAG_CONFIRM_EN
    .clk_i          (clk),
    .reset_i        (reset),
`endif
    .arm_i          (arm_hi),
    .sample_i       (sample),
    .sample_valid_i (sample_valid),
    .threshold_i    (thr_hi_q),
    .cnt_i          (cnt_q),
    .hit_o          (hi_hit),
    .hit_ts_o       (hi_ts)
  );

  // Measurement sequencer with registered result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      thr_lo_q       <= '0;
      thr_hi_q       <= '0;
      lag_q          <= '0;
      rise_q         <= '0;
      t_lo_q         <= '0;
      to_flag_q      <= 1'b0;
      busy_q         <= 1'b0;
      lag_cycles_q   <= '0;
      rise_cycles_q  <= '0;
      timeout_q      <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (trigger) begin
            thr_lo_q  <= thr_lo;
            thr_hi_q  <= thr_hi;
            cnt_q     <= CNT_W'(1);
            to_flag_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= WAIT_LO;
          end
        end
        WAIT_LO: begin
          cnt_q <= cnt_q + CNT_W'(1);
          // Timeout wins so every reported stamp stays below TO_CNT.
          if (cnt_q == TO_CNT) begin
            lag_q     <= ONES;
            rise_q    <= ONES;
            to_flag_q <= 1'b1;
            state_q   <= DONE;
          end else if (lo_hit) begin
            lag_q  <= lo_ts;
            t_lo_q <= lo_ts;
            if (hi_hit || (thr_hi_q <= thr_lo_q)) begin
              rise_q  <= '0;
              state_q <= DONE;
            end else begin
              state_q <= WAIT_HI;
            end
          end
        end
        WAIT_HI: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == TO_CNT) begin
            rise_q    <= ONES;
            to_flag_q <= 1'b1;
            state_q   <= DONE;
          end else if (hi_hit) begin
            rise_q  <= hi_ts - t_lo_q;
            state_q <= DONE;
          end
        end
        DONE: begin
          lag_cycles_q   <= lag_q;
          rise_cycles_q  <= rise_q;
          timeout_q      <= to_flag_q;
          result_valid_q <= 1'b1;
          busy_q         <= 1'b0;
          state_q        <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy         = busy_q;
  assign lag_cycles   = lag_cycles_q;
  assign rise_cycles  = rise_cycles_q;
  assign timeout      = timeout_q;
  assign result_valid = result_valid_q;

endmodule
